// File: rtl/mult_job_sequencer.sv
// Operand feeder and result collector for the leading-one multiplier: a small
// operand FIFO, a one-job-at-a-time issue FSM and a single-entry result register.
//
// state | meaning
// IDLE  | waiting for a queued operand pair and a free result register
// ISSUE | mult_start asserted for this single cycle, operands presented
// WAIT  | operands held until mult_done or until the timeout expires
module mult_job_sequencer #(
   parameter int DATA_W      = 16,
   parameter int RES_W       = 32,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   output logic                     mult_start,
   output logic [DATA_W-1:0]        mult_a,
   output logic [DATA_W-1:0]        mult_b,
   input  logic                     mult_done,
   input  logic [RES_W-1:0]         mult_res,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RES_W-1:0]         out_res,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_mem_a [DEPTH];
   logic [DATA_W-1:0]   r_mem_b [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [TMR_W-1:0]    r_tmr;
   logic                r_mult_start;
   logic [DATA_W-1:0]   r_mult_a;
   logic [DATA_W-1:0]   r_mult_b;
   logic                r_out_valid;
   logic [RES_W-1:0]    r_out_res;
   logic                r_err;

   logic                w_in_ready;
   logic                w_push;
   logic                w_pop;

   // Ready comes from the registered count only, so a full FIFO refuses a
   // push even in a cycle where the head is being popped.
   assign w_in_ready = (r_cnt != CNT_W'(DEPTH));
   assign w_push     = in_valid && w_in_ready;
   assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0) && !r_out_valid;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_tmr        <= '0;
         r_mult_start <= 1'b0;
         r_mult_a     <= '0;
         r_mult_b     <= '0;
         r_out_valid  <= 1'b0;
         r_out_res    <= '0;
         r_err        <= 1'b0;
      end else begin
         r_mult_start <= 1'b0;
         if (r_out_valid && out_ready) r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_mult_a     <= r_mem_a[r_rd_ptr];
                  r_mult_b     <= r_mem_b[r_rd_ptr];
                  r_mult_start <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_tmr   <= TMR_W'(TIMEOUT_CYC - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A done arriving in the last allowed cycle still wins over the timeout.
               if (mult_done) begin
                  r_out_res   <= mult_res;
                  r_out_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (r_tmr == '0) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = w_in_ready;
   assign mult_start = r_mult_start;
   assign mult_a     = r_mult_a;
   assign mult_b     = r_mult_b;
   assign out_valid  = r_out_valid;
   assign out_res    = r_out_res;
   assign busy       = (r_state != S_IDLE);
   assign fifo_cnt   = r_cnt;
   assign err        = r_err;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer: the bench plays both the operand source
// and the multiplier, with hand-computed products as expected results.
module tb_mult_job_sequencer;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_a;
   logic [15:0]   in_b;
   logic          mult_start;
   logic [15:0]   mult_a;
   logic [15:0]   mult_b;
   logic          mult_done;
   logic [31:0]   mult_res;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_res;
   logic          busy;
   logic [2:0]    fifo_cnt;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;

   mult_job_sequencer #(
      .DATA_W(16), .RES_W(32), .DEPTH(4), .TIMEOUT_CYC(255)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_done(mult_done), .mult_res(mult_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .busy(busy), .fifo_cnt(fifo_cnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] b);
      chk("push_in_ready", in_ready, 1'b1);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for the job to issue unless it already has, then completes it.
   task automatic serve(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] res, input bit already);
      int n;
      if (!already) begin
         n = 0;
         while (!mult_start && n < 20) begin
            tick();
            n++;
         end
         chk("serve_start_seen", mult_start, 1'b1);
      end
      chk("serve_mult_a", mult_a, a);
      chk("serve_mult_b", mult_b, b);
      tick();
      tick();
      chk("serve_mult_a_held", mult_a, a);
      mult_done = 1'b1;
      mult_res  = res;
      tick();
      mult_done = 1'b0;
      mult_res  = '0;
      chk("serve_out_valid", out_valid, 1'b1);
      chk("serve_out_res", out_res, res);
      tick();
      chk("serve_out_consumed", out_valid, 1'b0);
   endtask

   initial begin
      bit saw_start;
      int n;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      mult_done = 1'b0;
      mult_res  = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_fifo_cnt", fifo_cnt, 3'd0);
      chk("rst_mult_start", mult_start, 1'b0);
      chk("rst_mult_a", mult_a, 16'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_res", out_res, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b1;
      tick();

      // single job, 3 x 5
      push(16'h0003, 16'h0005);
      chk("t1_cnt_after_push", fifo_cnt, 3'd1);
      chk("t1_no_start_yet", mult_start, 1'b0);
      tick();
      chk("t1_start", mult_start, 1'b1);
      chk("t1_mult_a", mult_a, 16'h0003);
      chk("t1_mult_b", mult_b, 16'h0005);
      chk("t1_cnt_popped", fifo_cnt, 3'd0);
      chk("t1_busy", busy, 1'b1);
      tick();
      chk("t1_start_one_cycle", mult_start, 1'b0);
      tick();
      tick();
      chk("t1_mult_a_held", mult_a, 16'h0003);
      chk("t1_mult_b_held", mult_b, 16'h0005);
      mult_done = 1'b1;
      mult_res  = 32'h0000_000F;
      tick();
      mult_done = 1'b0;
      mult_res  = '0;
      chk("t1_out_valid", out_valid, 1'b1);
      chk("t1_out_res", out_res, 32'h0000_000F);
      chk("t1_idle", busy, 1'b0);
      tick();
      chk("t1_out_valid_hold", out_valid, 1'b1);
      chk("t1_no_restart", mult_start, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("t1_out_consumed", out_valid, 1'b0);
      out_ready = 1'b0;

      // stray done while idle
      mult_done = 1'b1;
      mult_res  = 32'h0000_DEAD;
      tick();
      mult_done = 1'b0;
      mult_res  = '0;
      chk("t5_out_valid", out_valid, 1'b0);
      chk("t5_out_res", out_res, 32'h0000_000F);
      chk("t5_busy", busy, 1'b0);

      // job whose result is left unconsumed, then fill behind it
      push(16'h0007, 16'h0009);
      n = 0;
      while (!mult_start && n < 20) begin
         tick();
         n++;
      end
      chk("t2_x_start", mult_start, 1'b1);
      chk("t2_x_mult_a", mult_a, 16'h0007);
      tick();
      mult_done = 1'b1;
      mult_res  = 32'h0000_003F;
      tick();
      mult_done = 1'b0;
      mult_res  = '0;
      chk("t2_x_out_valid", out_valid, 1'b1);
      chk("t2_x_out_res", out_res, 32'h0000_003F);
      push(16'h0011, 16'h0002);
      push(16'h0100, 16'h0100);
      push(16'hFFFF, 16'hFFFF);
      push(16'h1234, 16'h0010);
      chk("t2_full_cnt", fifo_cnt, 3'd4);
      chk("t2_full_in_ready", in_ready, 1'b0);
      in_a     = 16'h00AB;
      in_b     = 16'h0003;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_held_cnt", fifo_cnt, 3'd4);
         chk("t3_no_start", mult_start, 1'b0);
      end
      chk("t3_out_res_held", out_res, 32'h0000_003F);
      out_ready = 1'b1;
      tick();
      chk("t3_out_cleared", out_valid, 1'b0);
      chk("t3_start_not_yet", mult_start, 1'b0);
      chk("t3_still_full", in_ready, 1'b0);
      tick();
      chk("t3_start_2_later", mult_start, 1'b1);
      chk("t3_cnt_after_pop", fifo_cnt, 3'd3);
      tick();
      in_valid = 1'b0;
      chk("t2_fifth_accepted", fifo_cnt, 3'd4);
      serve(16'h0011, 16'h0002, 32'h0000_0022, 1'b1);
      serve(16'h0100, 16'h0100, 32'h0001_0000, 1'b0);
      serve(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
      serve(16'h1234, 16'h0010, 32'h0001_2340, 1'b0);
      serve(16'h00AB, 16'h0003, 32'h0000_0201, 1'b0);
      chk("t2_drained", fifo_cnt, 3'd0);

      // timeout: multiplier never answers
      push(16'h0002, 16'h0004);
      n = 0;
      while (!mult_start && n < 20) begin
         tick();
         n++;
      end
      chk("t4_start", mult_start, 1'b1);
      repeat (255) tick();
      chk("t4_err_not_yet", err, 1'b0);
      chk("t4_still_waiting", busy, 1'b1);
      tick();
      chk("t4_err", err, 1'b1);
      chk("t4_idle", busy, 1'b0);
      chk("t4_no_result", out_valid, 1'b0);
      push(16'h0006, 16'h0007);
      serve(16'h0006, 16'h0007, 32'h0000_002A, 1'b0);
      chk("t4_err_sticky", err, 1'b1);

      // async reset mid-job with three entries queued
      push(16'h0001, 16'h0001);
      push(16'h0002, 16'h0002);
      push(16'h0003, 16'h0003);
      push(16'h0004, 16'h0004);
      chk("t6_cnt_before", fifo_cnt, 3'd3);
      chk("t6_busy_before", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk("t6_fifo_cnt", fifo_cnt, 3'd0);
      chk("t6_in_ready", in_ready, 1'b1);
      chk("t6_busy", busy, 1'b0);
      chk("t6_mult_start", mult_start, 1'b0);
      chk("t6_mult_a", mult_a, 16'h0);
      chk("t6_mult_b", mult_b, 16'h0);
      chk("t6_out_valid", out_valid, 1'b0);
      chk("t6_out_res", out_res, 32'h0);
      chk("t6_err", err, 1'b0);
      #1;
      rst = 1'b1;
      saw_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         saw_start |= mult_start;
      end
      chk("t6_no_start_after", saw_start, 1'b0);
      chk("t6_cnt_after", fifo_cnt, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
